// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from ID/EX/MEM and stage-register controls for the pipeline controller.
interface pipeline_ctrl_if;

    logic [pipeline_ctrl_pkg::REG_IDX_W-1:0] id_rs1;
    logic [pipeline_ctrl_pkg::REG_IDX_W-1:0] id_rs2;
    logic                                    ex_mem_read;
    logic [pipeline_ctrl_pkg::REG_IDX_W-1:0] ex_rd;
    logic                                    ex_branch_taken;
    logic                                    mem_req;
    logic                                    mem_ready;

    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
    logic mem_timeout;

    modport slave (
        input  id_rs1, id_rs2, ex_mem_read, ex_rd, ex_branch_taken, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               mem_wb_bubble, mem_timeout
    );

    modport master (
        output id_rs1, id_rs2, ex_mem_read, ex_rd, ex_branch_taken, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               mem_wb_bubble, mem_timeout
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    output logic                 load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with data-memory wait timeout.
// Optional performance counters enabled by macro PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.slave   pif
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam int                WCNT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] cnt, cnt_nxt;
    logic              load_use;
    logic              mem_stall;
    logic              pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic              if_id_flush, id_ex_flush, mem_wb_bubble;

    hazard_detect u_hazard (
        .ex_mem_read (pif.ex_mem_read),
        .ex_rd       (pif.ex_rd),
        .id_rs1      (pif.id_rs1),
        .id_rs2      (pif.id_rs2),
        .load_use    (load_use)
    );

    assign mem_stall = pif.mem_req && !pif.mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        state_nxt     = state;
        cnt_nxt       = cnt;

        if (state == HALT) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            // cnt holds stalls already seen; this cycle is stall number cnt+1.
            if (state == RUN) begin
                if (WAIT_MAX <= 1) begin
                    state_nxt = HALT;
                end else begin
                    state_nxt = MEM_WAIT;
                    cnt_nxt   = WCNT_W'(1);
                end
            end else if (cnt == WAIT_LAST) begin
                state_nxt = HALT;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else begin
            // Completion (or a dropped request) advances the pipeline this same cycle.
            state_nxt = RUN;
            cnt_nxt   = '0;
            if (pif.ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign pif.pc_en         = pc_en;
    assign pif.if_id_en      = if_id_en;
    assign pif.id_ex_en      = id_ex_en;
    assign pif.ex_mem_en     = ex_mem_en;
    assign pif.if_id_flush   = if_id_flush;
    assign pif.id_ex_flush   = id_ex_flush;
    assign pif.mem_wb_bubble = mem_wb_bubble;
    assign pif.mem_timeout   = (state == HALT);

`ifdef PIPELINE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
            if (if_id_flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] unused_perf;
    assign unused_perf = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios plus random traffic
// against a flag/count-based reference model.
module tb_pipeline_ctrl;

    localparam int WAIT_MAX = 15;
`ifdef PIPELINE_CTRL_PERF_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if pif();

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

    pipeline_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pif          (pif)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: halted flag, run length of consecutive memory stalls, event counts.
    bit     halted;
    int     consec;
    longint m_stall, m_flush;
    longint cnt_max = (64'd1 << CNT_W) - 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_out();
        // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout}
        bit lu;
        lu = pif.ex_mem_read && pif.ex_rd != 0 &&
             (pif.ex_rd == pif.id_rs1 || pif.ex_rd == pif.id_rs2);
        if (halted)                            return 8'b0000_0011;
        if (pif.mem_req && !pif.mem_ready)     return 8'b0000_0010;
        if (pif.ex_branch_taken)               return 8'b1111_1100;
        if (lu)                                return 8'b0011_0100;
        return 8'b1111_0000;
    endfunction

    function automatic logic [7:0] dut_out();
        return {pif.pc_en, pif.if_id_en, pif.id_ex_en, pif.ex_mem_en,
                pif.if_id_flush, pif.id_ex_flush, pif.mem_wb_bubble, pif.mem_timeout};
    endfunction

    task automatic model_reset();
        halted  = 1'b0;
        consec  = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic drive(input int rs1, input int rs2, input int rd, input bit mr,
                         input bit br, input bit mq, input bit rdy);
        pif.id_rs1          = 5'(rs1);
        pif.id_rs2          = 5'(rs2);
        pif.ex_rd           = 5'(rd);
        pif.ex_mem_read     = mr;
        pif.ex_branch_taken = br;
        pif.mem_req         = mq;
        pif.mem_ready       = rdy;
    endtask

    // Check outputs mid-cycle, then advance one clock and update the model.
    task automatic step(input string tag);
        logic [7:0] e;
        #1;
        e = model_out();
        chk(tag, 64'(dut_out()), 64'(e));
`ifdef PIPELINE_CTRL_PERF_EN
        chk({tag, "_stall_cnt"}, 64'(stall_cycles), 64'(m_stall));
        chk({tag, "_flush_cnt"}, 64'(flush_count), 64'(m_flush));
`endif
        @(posedge clk);
        if (rst) begin
            if (!halted) begin
                if (pif.mem_req && !pif.mem_ready) begin
                    consec++;
                    if (consec == WAIT_MAX) halted = 1'b1;
                end else begin
                    consec = 0;
                end
            end
            if (!e[7] && m_stall < cnt_max) m_stall++;
            if (e[3] && m_flush < cnt_max) m_flush++;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        step("reset_hold");
        rst = 1'b1;
        step("idle0");
        step("idle1");

        // Load-use on rs2, one bubble then normal; ex_rd=0 never stalls.
        drive(1, 5, 5, 1, 0, 0, 1); step("load_use_rs2");
        drive(1, 2, 5, 0, 0, 0, 1); step("after_load_use");
        drive(0, 0, 0, 1, 0, 0, 1); step("load_use_x0");
        drive(7, 3, 7, 1, 0, 0, 1); step("load_use_rs1");

        // Branch, and branch together with load-use.
        drive(1, 2, 3, 0, 1, 0, 1); step("branch");
        drive(5, 1, 5, 1, 1, 0, 1); step("branch_and_load_use");
        drive(0, 0, 0, 0, 0, 0, 1); step("post_branch");

        // Three wait cycles, then completion advances the pipeline.
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step($sformatf("mem_wait%0d", i));
        drive(0, 0, 0, 0, 0, 1, 1); step("mem_done");
        drive(0, 0, 0, 0, 0, 0, 1); step("mem_after");

        // Request dropped mid-wait counts as completion; branch evaluated that cycle.
        drive(0, 0, 0, 0, 0, 1, 0); step("drop_wait");
        drive(0, 0, 0, 0, 1, 0, 0); step("drop_release");

        // Timeout: 16 stalled cycles requested, halt is sticky afterwards.
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) step($sformatf("timeout%0d", i));
        drive(0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) step($sformatf("halt_sticky%0d", i));

        // Asynchronous reset away from any clock edge.
        #2 rst = 1'b0;
        model_reset();
        step("async_reset");
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        step("after_reset");

        // Random traffic with periodic long waits and occasional resets.
        for (int i = 0; i < 600; i++) begin
            bit mq, rdy;
            mq  = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if ((i % 200) >= 150 && (i % 200) < 170) begin
                mq  = 1'b1;
                rdy = ($urandom_range(0, 19) == 0);
            end
            drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), mq, rdy);
            if ((i % 200) == 185) begin
                rst = 1'b0;
                model_reset();
            end else begin
                rst = 1'b1;
            end
            step($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
